// File: rtl/wvb_rd_addr_ctrl_mc.sv
// Multi-channel waveform buffer read-address controller.
// One read pointer per channel. A single header path and readout engine is
// shared by all channels. Header latency and header field positions are
// parameters. Reports words remaining, last word and a sticky protocol error.
module wvb_rd_addr_ctrl_mc #(
  parameter int unsigned P_N_CH      = 8,
  parameter int unsigned P_ADR_WIDTH = 12,
  parameter int unsigned P_HDR_WIDTH = 80,
  parameter int unsigned P_START_LSB = 49,
  parameter int unsigned P_STOP_LSB  = 37,
  parameter int unsigned P_HDR_LAT   = 2,
  localparam int unsigned CH_W       = (P_N_CH > 1) ? $clog2(P_N_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hdr_rdreq,
  input  logic [CH_W-1:0]               hdr_ch,
  input  logic [P_HDR_WIDTH-1:0]        hdr_data,
  input  logic                          wvb_rdreq,
  input  logic                          wvb_rddone,
  input  logic                          err_clr,
  output logic [P_N_CH*P_ADR_WIDTH-1:0] wvb_rd_addr,
  output logic [CH_W-1:0]               rd_ch,
  output logic                          rd_active,
  output logic [P_ADR_WIDTH:0]          rd_words_left,
  output logic                          rd_last,
  output logic                          seq_err
);

  localparam int unsigned W     = P_ADR_WIDTH;
  localparam int unsigned CNT_W = $clog2(P_HDR_LAT + 1);

  // Channel count widened by one bit so the range check is meaningful for
  // both power-of-two and non-power-of-two channel counts.
  localparam logic [CH_W:0]    N_CH_C   = (CH_W + 1)'(P_N_CH);
  localparam logic [CNT_W-1:0] LAT_M1_C = CNT_W'(P_HDR_LAT - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHdrWait = 2'd1,
    StRead    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic [W:0]       words_q, words_d;
  logic [W-1:0]     stop_q, stop_d;
  logic [W-1:0]     addr_q [P_N_CH];
  logic [W-1:0]     addr_d [P_N_CH];
  logic             err_q, err_d;
  logic             err_now;

  logic [W-1:0]     hdr_start;
  logic [W-1:0]     hdr_stop;
  logic             hdr_ch_ok;

  assign hdr_start = hdr_data[P_START_LSB +: W];
  assign hdr_stop  = hdr_data[P_STOP_LSB +: W];
  assign hdr_ch_ok = ({1'b0, hdr_ch} < N_CH_C);

  // State register and all datapath registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_ch_q <= '0;
      words_q <= '0;
      stop_q  <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < P_N_CH; i++) begin
        addr_q[i] <= '1;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_ch_q <= rd_ch_d;
      words_q <= words_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < P_N_CH; i++) begin
        addr_q[i] <= addr_d[i];
      end
    end
  end

  // Next-state, pointer update and protocol error detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_ch_d = rd_ch_q;
    words_d = words_q;
    stop_d  = stop_q;
    err_now = 1'b0;
    for (int unsigned i = 0; i < P_N_CH; i++) begin
      addr_d[i] = addr_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (hdr_rdreq) begin
          if (hdr_ch_ok) begin
            rd_ch_d = hdr_ch;
            cnt_d   = '0;
            state_d = StHdrWait;
          end else begin
            err_now = 1'b1;
          end
        end
        // Word traffic with no readout in progress is a sequencing error.
        if (wvb_rdreq || wvb_rddone) begin
          err_now = 1'b1;
        end
      end

      StHdrWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (hdr_rdreq || wvb_rdreq || wvb_rddone) begin
          err_now = 1'b1;
        end
        // Counter starts at 0 the cycle after the request, so LAT-1 marks
        // the cycle where hdr_data becomes valid.
        if (cnt_q == LAT_M1_C) begin
          for (int unsigned i = 0; i < P_N_CH; i++) begin
            if (CH_W'(i) == rd_ch_q) begin
              addr_d[i] = hdr_start;
            end
          end
          stop_d  = hdr_stop;
          // Modular distance plus one; a full buffer yields 2^W.
          words_d = {1'b0, hdr_stop - hdr_start} + (W + 1)'(1);
          state_d = StRead;
        end
      end

      StRead: begin
        if (hdr_rdreq) begin
          err_now = 1'b1;
        end
        if (wvb_rddone) begin
          // Done overrides any simultaneous word request.
          for (int unsigned i = 0; i < P_N_CH; i++) begin
            if (CH_W'(i) == rd_ch_q) begin
              addr_d[i] = stop_q + W'(1);
            end
          end
          words_d = '0;
          state_d = StIdle;
        end else if (wvb_rdreq) begin
          for (int unsigned i = 0; i < P_N_CH; i++) begin
            if (CH_W'(i) == rd_ch_q) begin
              addr_d[i] = addr_q[i] + W'(1);
            end
          end
          if (words_q == '0) begin
            err_now = 1'b1;
          end else begin
            words_d = words_q - (W + 1)'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Sticky error: a new error takes priority over a clear.
    if (err_now) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Flatten per-channel pointers onto the output bus.
  for (genvar k = 0; k < P_N_CH; k++) begin : g_addr_out
    assign wvb_rd_addr[k*W +: W] = addr_q[k];
  end

  assign rd_ch         = rd_ch_q;
  assign rd_active     = (state_q == StHdrWait) || (state_q == StRead);
  assign rd_words_left = words_q;
  assign rd_last       = rd_active && (state_q == StRead) && (words_q == (W + 1)'(1));
  assign seq_err       = err_q;

endmodule

// File: tb/tb_wvb_rd_addr_ctrl_mc.sv
// Self-checking bench for wvb_rd_addr_ctrl_mc: default instance plus a
// single-channel, latency-4 instance.
module tb_wvb_rd_addr_ctrl_mc;

  localparam int W = 12;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          hdr_rdreq, wvb_rdreq, wvb_rddone, err_clr;
  logic [2:0]    hdr_ch;
  logic [79:0]   hdr_data;
  logic [N*W-1:0] wvb_rd_addr;
  logic [2:0]    rd_ch;
  logic          rd_active, rd_last, seq_err;
  logic [W:0]    rd_words_left;

  logic          hdr_rdreq1, wvb_rdreq1, wvb_rddone1, err_clr1;
  logic [0:0]    hdr_ch1;
  logic [W-1:0]  addr1;
  logic [0:0]    rd_ch1;
  logic          rd_active1, rd_last1, seq_err1;
  logic [W:0]    words1;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_addr_q[$];
  logic [W-1:0] exp_a;

  wvb_rd_addr_ctrl_mc dut (
    .clk(clk), .rst(rst), .hdr_rdreq(hdr_rdreq), .hdr_ch(hdr_ch), .hdr_data(hdr_data),
    .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone), .err_clr(err_clr),
    .wvb_rd_addr(wvb_rd_addr), .rd_ch(rd_ch), .rd_active(rd_active),
    .rd_words_left(rd_words_left), .rd_last(rd_last), .seq_err(seq_err)
  );

  wvb_rd_addr_ctrl_mc #(.P_N_CH(1), .P_HDR_LAT(4)) dut1 (
    .clk(clk), .rst(rst), .hdr_rdreq(hdr_rdreq1), .hdr_ch(hdr_ch1), .hdr_data(hdr_data),
    .wvb_rdreq(wvb_rdreq1), .wvb_rddone(wvb_rddone1), .err_clr(err_clr1),
    .wvb_rd_addr(addr1), .rd_ch(rd_ch1), .rd_active(rd_active1),
    .rd_words_left(words1), .rd_last(rd_last1), .seq_err(seq_err1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] junk();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  function automatic logic [79:0] make_hdr(input logic [W-1:0] start, input logic [W-1:0] stop);
    logic [79:0] h;
    h = junk();
    h[49 +: W] = start;
    h[37 +: W] = stop;
    return h;
  endfunction

  function automatic logic [W-1:0] slice(input int k);
    return wvb_rd_addr[k*W +: W];
  endfunction

  // Header request on the default instance (latency 2); header valid only in cycle 2.
  task automatic hdr_request(input logic [2:0] ch, input logic [W-1:0] start,
                             input logic [W-1:0] stop, input logic [W-1:0] prev,
                             input logic [W:0] exp_words);
    hdr_data = junk(); hdr_ch = ch; hdr_rdreq = 1'b1;
    tick();
    hdr_rdreq = 1'b0;
    tick();
    hdr_data = make_hdr(start, stop);
    checks++;
    if (slice(ch) !== prev) begin
      errors++; $display("FAIL hdr_early ch%0d: got %h want %h", ch, slice(ch), prev);
    end
    tick();
    hdr_data = junk();
    checks++;
    if (slice(ch) !== start) begin
      errors++; $display("FAIL hdr_land ch%0d: got %h want %h", ch, slice(ch), start);
    end
    checks++;
    if (rd_words_left !== exp_words) begin
      errors++; $display("FAIL hdr_words: got %0d want %0d", rd_words_left, exp_words);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (wvb_rd_addr !== {N{12'hFFF}}) begin
      errors++; $display("FAIL rst_addr: got %h want all FFF", wvb_rd_addr);
    end
    checks++;
    if ({rd_ch, rd_words_left, rd_active, rd_last, seq_err} !== 19'd0) begin
      errors++; $display("FAIL rst_ctl: got ch=%0d words=%0d act=%b last=%b err=%b want zeros",
                         rd_ch, rd_words_left, rd_active, rd_last, seq_err);
    end
    checks++;
    if ({addr1, words1, rd_active1, seq_err1} !== {12'hFFF, 13'd0, 2'b00}) begin
      errors++; $display("FAIL rst_dut1: got addr=%h words=%0d act=%b err=%b want FFF/0/0/0",
                         addr1, words1, rd_active1, seq_err1);
    end
  endtask

  task automatic test_basic_read();
    hdr_request(3'd3, 12'h100, 12'h103, 12'hFFF, 13'd4);
    checks++;
    if (rd_active !== 1'b1 || rd_ch !== 3'd3) begin
      errors++; $display("FAIL basic_sel: got act=%b ch=%0d want 1/3", rd_active, rd_ch);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_last !== (i == 3)) begin
        errors++; $display("FAIL basic_last word%0d: got %b want %b", i, rd_last, (i == 3));
      end
      wvb_rdreq = 1'b1;
      exp_addr_q.push_back(12'h101 + 12'(i));
      tick();
      wvb_rdreq = 1'b0;
      exp_a = exp_addr_q.pop_front();
      checks++;
      if (slice(3) !== exp_a) begin
        errors++; $display("FAIL basic_addr word%0d: got %h want %h", i, slice(3), exp_a);
      end
    end
    checks++;
    if (rd_words_left !== 13'd0) begin
      errors++; $display("FAIL basic_words_end: got %0d want 0", rd_words_left);
    end
    wvb_rddone = 1'b1;
    tick();
    wvb_rddone = 1'b0;
    checks++;
    if (slice(3) !== 12'h104 || rd_active !== 1'b0 || seq_err !== 1'b0) begin
      errors++; $display("FAIL basic_done: got addr=%h act=%b err=%b want 104/0/0",
                         slice(3), rd_active, seq_err);
    end
    for (int k = 0; k < N; k++) begin
      if (k != 3) begin
        checks++;
        if (slice(k) !== 12'hFFF) begin
          errors++; $display("FAIL basic_other ch%0d: got %h want FFF", k, slice(k));
        end
      end
    end
  endtask

  task automatic test_wrap();
    hdr_request(3'd0, 12'hFFE, 12'h001, 12'hFFF, 13'd4);
    for (int i = 0; i < 3; i++) begin
      wvb_rdreq = 1'b1;
      exp_addr_q.push_back(12'hFFF + 12'(i));
      tick();
      wvb_rdreq = 1'b0;
      exp_a = exp_addr_q.pop_front();
      checks++;
      if (slice(0) !== exp_a) begin
        errors++; $display("FAIL wrap_addr step%0d: got %h want %h", i, slice(0), exp_a);
      end
    end
    wvb_rddone = 1'b1;
    tick();
    wvb_rddone = 1'b0;
    checks++;
    if (slice(0) !== 12'h002) begin
      errors++; $display("FAIL wrap_done: got %h want 002", slice(0));
    end
  endtask

  task automatic test_early_done();
    hdr_request(3'd5, 12'h200, 12'h207, 12'hFFF, 13'd8);
    wvb_rdreq = 1'b1;
    tick(); tick();
    checks++;
    if (slice(5) !== 12'h202 || rd_words_left !== 13'd6) begin
      errors++; $display("FAIL early_mid: got addr=%h words=%0d want 202/6", slice(5), rd_words_left);
    end
    wvb_rddone = 1'b1;
    tick();
    wvb_rdreq = 1'b0; wvb_rddone = 1'b0;
    checks++;
    if (slice(5) !== 12'h208 || rd_words_left !== 13'd0 || seq_err !== 1'b0 || rd_active !== 1'b0) begin
      errors++; $display("FAIL early_done: got addr=%h words=%0d err=%b act=%b want 208/0/0/0",
                         slice(5), rd_words_left, seq_err, rd_active);
    end
  endtask

  task automatic test_protocol_errors();
    logic [N*W-1:0] snap;
    snap = wvb_rd_addr;
    wvb_rdreq = 1'b1;
    tick();
    wvb_rdreq = 1'b0;
    checks++;
    if (seq_err !== 1'b1 || wvb_rd_addr !== snap || rd_active !== 1'b0) begin
      errors++; $display("FAIL err_idle_rdreq: got err=%b act=%b addr=%h want 1/0/%h",
                         seq_err, rd_active, wvb_rd_addr, snap);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (seq_err !== 1'b0) begin
      errors++; $display("FAIL err_clr_idle: got %b want 0", seq_err);
    end
    hdr_request(3'd2, 12'h300, 12'h301, 12'hFFF, 13'd2);
    hdr_rdreq = 1'b1; hdr_ch = 3'd7;
    tick();
    checks++;
    if (seq_err !== 1'b1 || rd_ch !== 3'd2 || slice(2) !== 12'h300 || rd_words_left !== 13'd2
        || rd_active !== 1'b1) begin
      errors++; $display("FAIL err_hdr_in_read: got err=%b ch=%0d addr=%h words=%0d act=%b",
                         seq_err, rd_ch, slice(2), rd_words_left, rd_active);
    end
    err_clr = 1'b1;
    tick();
    hdr_rdreq = 1'b0;
    checks++;
    if (seq_err !== 1'b1) begin
      errors++; $display("FAIL err_set_wins: got %b want 1", seq_err);
    end
    tick();
    err_clr = 1'b0;
    checks++;
    if (seq_err !== 1'b0) begin
      errors++; $display("FAIL err_clr_read: got %b want 0", seq_err);
    end
    wvb_rddone = 1'b1;
    tick();
    wvb_rddone = 1'b0;
    checks++;
    if (slice(2) !== 12'h302) begin
      errors++; $display("FAIL err_done: got %h want 302", slice(2));
    end
  endtask

  task automatic test_overread();
    hdr_request(3'd6, 12'h010, 12'h010, 12'hFFF, 13'd1);
    checks++;
    if (rd_last !== 1'b1) begin
      errors++; $display("FAIL over_last: got %b want 1", rd_last);
    end
    wvb_rdreq = 1'b1;
    tick();
    checks++;
    if (slice(6) !== 12'h011 || rd_words_left !== 13'd0 || seq_err !== 1'b0) begin
      errors++; $display("FAIL over_first: got addr=%h words=%0d err=%b want 011/0/0",
                         slice(6), rd_words_left, seq_err);
    end
    tick();
    wvb_rdreq = 1'b0;
    checks++;
    if (slice(6) !== 12'h012 || rd_words_left !== 13'd0 || seq_err !== 1'b1) begin
      errors++; $display("FAIL over_second: got addr=%h words=%0d err=%b want 012/0/1",
                         slice(6), rd_words_left, seq_err);
    end
    wvb_rddone = 1'b1; err_clr = 1'b1;
    tick();
    wvb_rddone = 1'b0; err_clr = 1'b0;
    checks++;
    if (slice(6) !== 12'h011 || seq_err !== 1'b0) begin
      errors++; $display("FAIL over_done: got addr=%h err=%b want 011/0", slice(6), seq_err);
    end
  endtask

  task automatic test_reset_mid();
    hdr_data = junk(); hdr_ch = 3'd1; hdr_rdreq = 1'b1;
    tick();
    hdr_rdreq = 1'b0;
    hdr_data = make_hdr(12'h400, 12'h401);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (wvb_rd_addr !== {N{12'hFFF}} || rd_active !== 1'b0 || rd_ch !== 3'd0
        || rd_words_left !== 13'd0) begin
      errors++; $display("FAIL rst_hdrwait: got addr=%h act=%b ch=%0d words=%0d",
                         wvb_rd_addr, rd_active, rd_ch, rd_words_left);
    end
    tick(); tick(); tick();
    checks++;
    if (slice(1) !== 12'hFFF || rd_active !== 1'b0) begin
      errors++; $display("FAIL rst_hdrwait_late: got addr=%h act=%b want FFF/0", slice(1), rd_active);
    end
    hdr_request(3'd4, 12'h500, 12'h50F, 12'hFFF, 13'd16);
    wvb_rdreq = 1'b1;
    tick();
    wvb_rdreq = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (wvb_rd_addr !== {N{12'hFFF}} || rd_active !== 1'b0 || rd_words_left !== 13'd0
        || rd_ch !== 3'd0) begin
      errors++; $display("FAIL rst_read: got addr=%h act=%b words=%0d ch=%0d",
                         wvb_rd_addr, rd_active, rd_words_left, rd_ch);
    end
  endtask

  task automatic test_lat4_single();
    hdr_rdreq1 = 1'b1; hdr_ch1 = 1'b1;
    tick();
    hdr_rdreq1 = 1'b0;
    checks++;
    if (seq_err1 !== 1'b1 || rd_active1 !== 1'b0 || addr1 !== 12'hFFF) begin
      errors++; $display("FAIL l4_badch: got err=%b act=%b addr=%h want 1/0/FFF",
                         seq_err1, rd_active1, addr1);
    end
    err_clr1 = 1'b1;
    tick();
    err_clr1 = 1'b0;
    hdr_data = junk(); hdr_ch1 = 1'b0; hdr_rdreq1 = 1'b1;
    tick();
    hdr_rdreq1 = 1'b0;
    tick(); tick(); tick();
    hdr_data = make_hdr(12'h100, 12'h103);
    checks++;
    if (addr1 !== 12'hFFF || rd_active1 !== 1'b1 || seq_err1 !== 1'b0) begin
      errors++; $display("FAIL l4_early: got addr=%h act=%b err=%b want FFF/1/0",
                         addr1, rd_active1, seq_err1);
    end
    tick();
    hdr_data = junk();
    checks++;
    if (addr1 !== 12'h100 || words1 !== 13'd4) begin
      errors++; $display("FAIL l4_land: got addr=%h words=%0d want 100/4", addr1, words1);
    end
    wvb_rddone1 = 1'b1;
    tick();
    wvb_rddone1 = 1'b0;
    checks++;
    if (addr1 !== 12'h104 || rd_active1 !== 1'b0) begin
      errors++; $display("FAIL l4_done: got addr=%h act=%b want 104/0", addr1, rd_active1);
    end
  endtask

  initial begin
    rst = 1'b1;
    hdr_rdreq = 1'b0; hdr_ch = '0; hdr_data = '0;
    wvb_rdreq = 1'b0; wvb_rddone = 1'b0; err_clr = 1'b0;
    hdr_rdreq1 = 1'b0; hdr_ch1 = '0; wvb_rdreq1 = 1'b0; wvb_rddone1 = 1'b0; err_clr1 = 1'b0;
    #1;
    test_reset();
    test_basic_read();
    test_wrap();
    test_early_done();
    test_protocol_errors();
    test_overread();
    test_reset_mid();
    test_lat4_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wvb_rd_addr_ctrl_mc.md
Name: wvb_rd_addr_ctrl_mc

Overview:
- Multi-channel successor to the single-channel waveform buffer read-address controller.
- Keeps one read pointer per waveform buffer channel. All channels share one header path and one readout engine.
- Header field positions and header read latency are parameters.
- Adds a per-readout word counter, last-word flag, active-channel reporting and a sticky sequencing error flag.
- Sits between the readout arbiter/formatter (which selects a channel and requests header and waveform words) and the N_CH waveform buffer RAMs.

Parameters:
- P_N_CH, 8, number of waveform buffer channels (>=1). Localparam CH_W = max(1, clog2(P_N_CH)).
- P_ADR_WIDTH, 12, buffer address width; buffer depth is 2^P_ADR_WIDTH.
- P_HDR_WIDTH, 80, header bundle width.
- P_START_LSB, 49, LSB of the start_addr field in hdr_data (field width P_ADR_WIDTH).
- P_STOP_LSB, 37, LSB of the stop_addr field in hdr_data (field width P_ADR_WIDTH).
- P_HDR_LAT, 2, cycles from hdr_rdreq until hdr_data is valid (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- hdr_rdreq  in  1  header read request for channel hdr_ch
- hdr_ch  in  CH_W  channel being read; sampled with hdr_rdreq
- hdr_data  in  P_HDR_WIDTH  header of the selected channel, muxed externally
- wvb_rdreq  in  1  advance the read pointer by one word
- wvb_rddone  in  1  readout of the current channel finished
- err_clr  in  1  clears seq_err
- wvb_rd_addr  out  P_N_CH*P_ADR_WIDTH  per-channel read pointers; channel k occupies [k*W +: W]
- rd_ch  out  CH_W  channel latched at header request
- rd_active  out  1  high in states HDR_WAIT and READ
- rd_words_left  out  P_ADR_WIDTH+1  words remaining in the current waveform
- rd_last  out  1  rd_active && state==READ && rd_words_left==1
- seq_err  out  1  sticky protocol error flag

Behaviour:
- Reset values:
  - every wvb_rd_addr slice = all ones (-1)
  - rd_ch = 0, rd_words_left = 0, seq_err = 0
  - state = IDLE, wait counter = 0
  - rst mid-operation aborts any readout and returns to these values on the next edge.
- FSM states: IDLE, HDR_WAIT, READ.
- IDLE:
  - hdr_rdreq with hdr_ch < P_N_CH: latch rd_ch = hdr_ch, clear wait counter, go to HDR_WAIT.
  - hdr_rdreq with hdr_ch >= P_N_CH: ignored, seq_err set.
  - wvb_rdreq or wvb_rddone in IDLE: ignored, seq_err set; no pointer changes.
- HDR_WAIT:
  - Counter increments every cycle.
  - In the cycle exactly P_HDR_LAT cycles after the hdr_rdreq cycle, sample start = hdr_data[P_START_LSB +: W] and stop = hdr_data[P_STOP_LSB +: W].
  - On that edge: wvb_rd_addr[rd_ch] <= start; stop is latched internally; rd_words_left <= ((stop - start) mod 2^W) + 1; go to READ.
  - The new address is visible P_HDR_LAT+1 cycles after hdr_rdreq (3 cycles with the default latency).
  - hdr_rdreq, wvb_rdreq or wvb_rddone during HDR_WAIT: ignored, seq_err set.
- READ:
  - wvb_rdreq alone: wvb_rd_addr[rd_ch] increments mod 2^W (wrap from all ones to 0). rd_words_left decrements, saturating at 0.
  - wvb_rdreq while rd_words_left==0: the pointer still increments, and seq_err is set.
  - wvb_rddone (with or without a simultaneous wvb_rdreq): wvb_rd_addr[rd_ch] <= latched stop + 1 (mod 2^W); rd_words_left <= 0; go to IDLE. The simultaneous wvb_rdreq is discarded and no error is flagged.
  - hdr_rdreq in READ: ignored, seq_err set.
- Pointers of unselected channels never change except on reset.
- start == stop gives rd_words_left = 1. stop == start-1 (mod 2^W) gives a full-buffer count of 2^W, which the W+1-bit width holds.
- seq_err is set by any error above. It clears on err_clr only when no error occurs in the same cycle; set wins over clear.
- Single clock domain; no combinational path from inputs to outputs except rd_last, which is derived from registered state.

Test Plan:
- Reset, then read ch 3 with a header of start=0x100 and stop=0x103 at P_HDR_LAT=2: hdr_rdreq at cycle 0 → addr[3]=0x100 at cycle 3 and rd_words_left=4. Four wvb_rdreq → addr 0x104; rd_last high on the 4th word. wvb_rddone → addr[3]=0x104, IDLE. Other slices stay 0xFFF.
- Wrap-around on ch 0 with start=0xFFE, stop=0x001: rd_words_left=4; addresses go 0xFFE, 0xFFF, 0x000, 0x001. rddone → 0x002.
- Early done: after 2 of 8 words, assert wvb_rdreq and wvb_rddone together → addr = stop+1, no increment, seq_err stays 0.
- Protocol errors: a wvb_rdreq in IDLE, a hdr_rdreq during READ, and hdr_ch=P_N_CH (for non-power-of-2 P_N_CH) each set seq_err with state and pointers unchanged. err_clr then clears it.
- Overread: with start=stop=0x010, two wvb_rdreq → addr 0x012, rd_words_left=0, seq_err=1.
- rst asserted mid-HDR_WAIT and mid-READ → all pointers 0xFFF, IDLE, counters 0 next cycle. Repeat the first scenario with P_HDR_LAT=4 and P_N_CH=1 to check the new address lands at cycle 5.
